// File: rtl/booth_divider_if.sv
// Handshake and data bundle for booth_divider.
// The requester drives start/op/operands; the divider returns results and status.
interface booth_divider_if #(
  parameter int N = 32
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] result;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;

  modport master (
    output start, op, dividend, divisor,
    input  result, quotient, remainder, busy, done
  );

  modport slave (
    input  start, op, dividend, divisor,
    output result, quotient, remainder, busy, done
  );
endinterface

// File: rtl/booth_divider.sv
// Multi-cycle signed/unsigned integer divider.
// Operands are reduced to magnitudes on accept, divided by an N-step restoring
// loop, and sign-corrected in FIX. Divide-by-zero and signed overflow skip the
// loop and are resolved directly in FIX.
// op: 00 DIV, 01 DIVU, 10 REM, 11 REMU (op[0] = unsigned, op[1] = remainder).
module booth_divider #(
  parameter int N = 32
) (
  input logic            clk,
  input logic            rst_n,
  booth_divider_if.slave bus
);

  localparam int            CW      = $clog2(N) + 1;
  localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_DIV0, SP_OVF} special_t;

  state_t        state;
  special_t      special;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [N-1:0]  dividend_q;   // raw dividend, returned as remainder on divide-by-zero
  logic [N-1:0]  dvs_abs;      // |divisor| held for the whole loop
  logic [N-1:0]  rem;          // partial remainder
  logic [N-1:0]  q;            // dividend magnitude shifting out, quotient shifting in
  logic          sign_q;
  logic          sign_r;
  logic [N-1:0]  quotient_q;
  logic [N-1:0]  remainder_q;
  logic [N-1:0]  result_q;
  logic          busy_q;
  logic          done_q;

  logic          is_signed;
  logic          dvd_neg;
  logic          dvs_neg;
  logic          div_zero;
  logic          sgn_ovf;
  logic [N-1:0]  dvd_abs_in;
  logic [N-1:0]  dvs_abs_in;

  // Accept-cycle decode: operand signs, magnitudes and special cases.
  // Negating 2^(N-1) yields 2^(N-1) again, which is the correct magnitude
  // when the bits are read as unsigned.
  always_comb begin
    is_signed  = ~bus.op[0];
    dvd_neg    = is_signed & bus.dividend[N-1];
    dvs_neg    = is_signed & bus.divisor[N-1];
    dvd_abs_in = dvd_neg ? (-bus.dividend) : bus.dividend;
    dvs_abs_in = dvs_neg ? (-bus.divisor) : bus.divisor;
    div_zero   = (bus.divisor == '0);
    sgn_ovf    = is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  end

  logic [N:0]   shifted;
  logic [N:0]   diff;
  logic [N-1:0] rem_step;
  logic [N-1:0] q_step;

  // One restoring step: shift in the next dividend bit, trial-subtract in N+1
  // bits and keep the difference only when it did not go negative.
  always_comb begin
    shifted  = {rem, q[N-1]};
    diff     = shifted - {1'b0, dvs_abs};
    rem_step = diff[N] ? shifted[N-1:0] : diff[N-1:0];
    q_step   = {q[N-2:0], ~diff[N]};
  end

  logic [N-1:0] q_fix;
  logic [N-1:0] r_fix;

  // Final sign correction, overridden by the fixed special-case results.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    q_fix = sign_q ? (-q) : q;
    r_fix = sign_r ? (-rem) : rem;
    case (special)
      SP_DIV0: begin
        q_fix = '1;
        r_fix = dividend_q;
      end
      SP_OVF: begin
        q_fix = MIN_NEG;
        r_fix = '0;
      end
      default: ;
    endcase
  end

  // Control FSM with registered status and result outputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      special     <= SP_NONE;
      cnt         <= '0;
      op_q        <= '0;
      dividend_q  <= '0;
      dvs_abs     <= '0;
      rem         <= '0;
      q           <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // A start coinciding with the done pulse is dropped, not queued.
          if (bus.start && !done_q) begin
            op_q       <= bus.op;
            dividend_q <= bus.dividend;
            dvs_abs    <= dvs_abs_in;
            q          <= dvd_abs_in;
            rem        <= '0;
            sign_q     <= dvd_neg ^ dvs_neg;
            sign_r     <= dvd_neg;
            cnt        <= '0;
            busy_q     <= 1'b1;
            if (div_zero) begin
              special <= SP_DIV0;
              state   <= FIX;
            end else if (sgn_ovf) begin
              special <= SP_OVF;
              state   <= FIX;
            end else begin
              special <= SP_NONE;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_step;
          q   <= q_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= FIX;
        end
        FIX: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
          result_q    <= op_q[1] ? r_fix : q_fix;
          state       <= DONE;
        end
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: doc/booth_divider.md
BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 Parameter N, default 32, meaning operand width in bits (N even, N >= 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
REQ-006 dividend  input  N  numerator; two's complement when op[0]=0.
REQ-007 divisor  input  N  denominator; two's complement when op[0]=0.
REQ-008 result  output  N  quotient (op[1]=0) or remainder (op[1]=1).
REQ-009 quotient  output  N  full quotient, for debug and fused DIV/REM use.
REQ-010 remainder  output  N  full remainder.
REQ-011 busy  output  1  high from the cycle after accepted start until done.
REQ-012 done  output  1  one-cycle pulse; result valid in the same cycle.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 IDLE with start=1 SHALL latch op, compute |dividend| and |divisor|, record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend) (both signs 0 for unsigned ops), clear the partial remainder, and go to CALC.
REQ-015 The accept cycle SHALL instead go directly to FIX for the special cases: divisor = 0, or signed op with dividend = 2^(N-1) and divisor = all ones.
REQ-016 CALC SHALL perform one restoring step per cycle, N cycles total, using a $clog2(N)+1-bit counter:
  - shift {rem, q} left by 1;
  - trial-subtract |divisor| in N+1 bits;
  - keep the difference and set q LSB = 1 if it is non-negative, otherwise restore and set q LSB = 0.
REQ-017 FIX SHALL apply sign correction: negate q if sign_q = 1, negate rem if sign_r = 1, and register quotient and remainder.
REQ-018 For the special cases, FIX SHALL produce these results:
  - divisor = 0: quotient = all ones and remainder = dividend, for all ops;
  - signed overflow: quotient = 2^(N-1) and remainder = 0.
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-020 Normal latency SHALL be: start accepted at edge 0, done high after edge N+2 (N=32: 34 cycles).
REQ-021 Special-case latency SHALL be: done high after edge 2.
REQ-022 quotient, remainder and result SHALL hold their last values from done until the next FIX; they do not change while IDLE.
REQ-023 start while busy=1 or while done=1 SHALL be ignored, with no queuing.
REQ-024 Input changes after the accept cycle SHALL NOT affect the in-flight operation.
REQ-025 A start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back operation).
REQ-026 The nonzero remainder SHALL carry the sign of the dividend.
REQ-027 |quotient*divisor| + |remainder| SHALL equal |dividend|, and |remainder| < |divisor|, for every non-special case.
REQ-028 The intermediate negation of 2^(N-1) SHALL be handled in unsigned N-bit form without loss.

Reset
REQ-029 rst_n low SHALL immediately force:
  - FSM to IDLE and counter to 0;
  - busy = 0 and done = 0;
  - quotient, remainder and result to 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-031 The first start accepted after rst_n rises SHALL behave as a fresh operation.
REQ-032 Deassertion of rst_n SHALL be synchronised externally, and the block SHALL take no action on the release edge.

Verification
REQ-033 DIV, dividend = -345, divisor = 97 (N=32) -> after 34 cycles done=1, quotient = -3, remainder = -54, result = -3; busy high for cycles 1..33.
REQ-034 DIVU 100 / 7, then REMU 0xFFFFFFFF / 2 issued back-to-back in the cycle after done -> first: quotient = 14, remainder = 2; second: quotient = 0x7FFFFFFF, result = 1; no idle gap is needed beyond the IDLE cycle.
REQ-035 DIV 5 / 0 and REM -7 / 0 -> done after 2 cycles with quotient = 0xFFFFFFFF, and remainder = 5 and 0xFFFFFFF9 respectively.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> done after 2 cycles, quotient = 0x80000000, remainder = 0; the same operands as DIVU -> 34 cycles, quotient = 0, remainder = 0x80000000.
REQ-037 rst_n pulsed low at cycle 10 of a DIV -12 / 5 -> busy and done drop immediately, outputs read 0, and no done pulse occurs; the next start yields quotient = -2, remainder = -2.
REQ-038 start held high throughout an operation -> exactly one done per accepted start, and a re-accept occurs only in IDLE; a randomized 10k-vector comparison against a golden model covering all four ops SHALL show no mismatches.
